// File: rtl/spi_tx_engine.sv
// SPI mode-0 master frame engine: one SCLK edge per prescaler tick, MSB first,
// captures MISO on rising SCLK and pulses done when cs_n is released.
module spi_tx_engine #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              miso,
    output logic [DATA_W-1:0] rx_data,
    output logic              done,
    output logic              cs_n,
    output logic              sclk,
    output logic              mosi
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        TRAIL
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] rxreg;
    logic [CNT_W-1:0]  bit_cnt;

    assign tx_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (tx_valid) state_next = LOW;
            LOW:     if (tick) state_next = HIGH;
            HIGH:    if (tick) state_next = (bit_cnt == '0) ? TRAIL : LOW;
            TRAIL:   if (tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Serial datapath; mosi only moves on falling-edge ticks so it is always
    // settled a full tick before the slave samples it on the next rise.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cs_n    <= 1'b1;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            done    <= 1'b0;
            rx_data <= '0;
            shreg   <= '0;
            rxreg   <= '0;
            bit_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        shreg   <= tx_data;
                        mosi    <= tx_data[DATA_W-1];
                        cs_n    <= 1'b0;
                        bit_cnt <= CNT_W'(DATA_W - 1);
                    end
                end
                LOW: begin
                    if (tick) begin
                        sclk  <= 1'b1;
                        rxreg <= {rxreg[DATA_W-2:0], miso};
                    end
                end
                HIGH: begin
                    if (tick) begin
                        sclk <= 1'b0;
                        if (bit_cnt != '0) begin
                            shreg   <= shreg << 1;
                            mosi    <= shreg[DATA_W-2];
                            bit_cnt <= bit_cnt - CNT_W'(1);
                        end
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        cs_n    <= 1'b1;
                        mosi    <= 1'b0;
                        done    <= 1'b1;
                        rx_data <= rxreg;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
